// File: rtl/bcd_stopwatch_chain.sv
// Synchronous N-digit BCD stopwatch/timer with a clock-enable prescaler and a per-digit carry/borrow chain.
// Supports up/down counting, start/stop, clear, load, lap freeze and terminal detection.
module bcd_stopwatch_chain #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                dir,
    input  logic                lap,
    output logic [4*DIGITS-1:0] count,
    output logic [4*DIGITS-1:0] display,
    output logic                running,
    output logic                lap_active,
    output logic                tick,
    output logic                terminal
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          dir_q;
    logic [W-1:0]  lap_reg;
    logic [W-1:0]  stepped;
    logic [W-1:0]  next_count;
    logic [W-1:0]  load_clamped;
    logic          chain_en;
    logic          overflow;
    logic          step_terminal;
    logic          expire;

    // Ripple enable: a digit steps only when every lower digit rolls over (9->0 up, 0->9 down).
    always_comb begin
        stepped  = count;
        chain_en = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain_en) begin
                if (!dir_q)
                    stepped[4*i +: 4] = (count[4*i +: 4] >= 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
                else
                    stepped[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? 4'd9 : count[4*i +: 4] - 4'd1;
            end
            chain_en = chain_en & (dir_q ? (count[4*i +: 4] == 4'd0) : (count[4*i +: 4] == 4'd9));
        end
        overflow = !dir_q && chain_en;
    end

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
        end
    end

    assign next_count    = (overflow && (SATURATE != 0)) ? count : stepped;
    assign step_terminal = dir_q ? (stepped == '0) : overflow;
    assign tick          = (state == RUNNING) && (presc == PRESC_MAX);
    assign terminal      = tick && step_terminal;
    // Wrapping up-counts report terminal but keep running; everything else that terminates expires.
    assign expire        = terminal && (dir_q || (SATURATE != 0));
    assign running       = (state == RUNNING);
    assign display       = lap_active ? lap_reg : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STOPPED;
            count      <= '0;
            lap_reg    <= '0;
            lap_active <= 1'b0;
            presc      <= '0;
            dir_q      <= 1'b0;
        end else if (clear) begin
            count      <= '0;
            presc      <= '0;
            lap_reg    <= '0;
            lap_active <= 1'b0;
            if (state == EXPIRED)
                state <= STOPPED;
        end else begin
            if (load && (state != RUNNING)) begin
                count <= load_clamped;
                presc <= '0;
                state <= STOPPED;
            end else begin
                case (state)
                    STOPPED: begin
                        if (start_stop && !(dir && (count == '0))) begin
                            state <= RUNNING;
                            dir_q <= dir;
                        end
                    end
                    RUNNING: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick)
                            count <= next_count;
                        if (expire)
                            state <= EXPIRED;
                        else if (start_stop)
                            state <= STOPPED;
                    end
                    default: begin
                    end
                endcase
            end
            // The lap register snapshots the count as it was before this cycle's step.
            if (lap) begin
                if (!lap_active)
                    lap_reg <= count;
                lap_active <= !lap_active;
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_chain.sv
// Self-checking bench for bcd_stopwatch_chain: a 3-digit wrapping DUT, a 3-digit saturating DUT
// and a 2-digit DUT share one stimulus stream; expectations go through a scoreboard queue.
module tb_bcd_stopwatch_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        dir = 1'b0;
    logic        lap = 1'b0;
    logic [11:0] load_value = '0;

    logic [11:0] count_a, display_a, count_s, display_s;
    logic [7:0]  count_b, display_b;
    logic        running_a, lap_active_a, tick_a, terminal_a;
    logic        running_s, lap_active_s, tick_s, terminal_s;
    logic        running_b, lap_active_b, tick_b, terminal_b;

    int assertions = 0;
    int failures = 0;

    typedef struct {
        int          which;
        string       name;
        logic [11:0] count;
        logic [11:0] display;
        logic        running;
        logic        lap_active;
        logic        tick;
        logic        terminal;
    } exp_t;

    typedef struct {
        string       name;
        logic        ss;
        logic        clr;
        logic        ld;
        logic        d;
        logic [11:0] lv;
        logic [11:0] cnt;
        logic        run;
        logic        tk;
        logic        tm;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    bcd_stopwatch_chain #(.DIGITS(3), .TICK_DIV(4), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .load(load),
        .load_value(load_value), .dir(dir), .lap(lap),
        .count(count_a), .display(display_a), .running(running_a), .lap_active(lap_active_a),
        .tick(tick_a), .terminal(terminal_a)
    );

    bcd_stopwatch_chain #(.DIGITS(3), .TICK_DIV(4), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .load(load),
        .load_value(load_value), .dir(dir), .lap(lap),
        .count(count_s), .display(display_s), .running(running_s), .lap_active(lap_active_s),
        .tick(tick_s), .terminal(terminal_s)
    );

    bcd_stopwatch_chain #(.DIGITS(2), .TICK_DIV(4), .SATURATE(0)) dut_b (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .load(load),
        .load_value(load_value[7:0]), .dir(dir), .lap(lap),
        .count(count_b), .display(display_b), .running(running_b), .lap_active(lap_active_b),
        .tick(tick_b), .terminal(terminal_b)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd3(input int v);
        bcd3 = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic vec_t mk(input string n, input logic ss, input logic clr, input logic ld,
                                input logic d, input logic [11:0] lv, input logic [11:0] cnt,
                                input logic run, input logic tk, input logic tm);
        vec_t v;
        v.name = n; v.ss = ss; v.clr = clr; v.ld = ld; v.d = d; v.lv = lv;
        v.cnt = cnt; v.run = run; v.tk = tk; v.tm = tm;
        return v;
    endfunction

    task automatic pushExpect(input int which, input string name, input logic [11:0] c,
                              input logic [11:0] dsp, input logic r, input logic la,
                              input logic t, input logic te);
        exp_t e;
        e.which = which; e.name = name; e.count = c; e.display = dsp;
        e.running = r; e.lap_active = la; e.tick = t; e.terminal = te;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [11:0] ac, ad;
        logic        ar, al, at, ate;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.which)
                0: begin
                    ac = count_a; ad = display_a; ar = running_a;
                    al = lap_active_a; at = tick_a; ate = terminal_a;
                end
                1: begin
                    ac = count_s; ad = display_s; ar = running_s;
                    al = lap_active_s; at = tick_s; ate = terminal_s;
                end
                default: begin
                    ac = {4'h0, count_b}; ad = {4'h0, display_b}; ar = running_b;
                    al = lap_active_b; at = tick_b; ate = terminal_b;
                end
            endcase
            assertions++;
            if (ac !== e.count || ad !== e.display || ar !== e.running ||
                al !== e.lap_active || at !== e.tick || ate !== e.terminal) begin
                failures++;
                $display("[TB] FAIL %s dut%0d: got cnt=%h disp=%h run=%b lap=%b tick=%b term=%b, expected cnt=%h disp=%h run=%b lap=%b tick=%b term=%b",
                         e.name, e.which, ac, ad, ar, al, at, ate,
                         e.count, e.display, e.running, e.lap_active, e.tick, e.terminal);
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ss, input logic clr, input logic ld,
                                 input logic lp, input logic d, input logic [11:0] lv);
        reset = rst; start_stop = ss; clear = clr; load = ld; lap = lp; dir = d; load_value = lv;
        @(posedge clk);
        #1;
        reset = 1'b0; start_stop = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0;
        checkOutput();
    endtask

    task automatic doReset(input string name);
        for (int w = 0; w < 3; w++)
            pushExpect(w, name, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        logic [11:0] c, dsp;
        logic        la;

        // Table for the down-count expiry and single-cycle corner cases on the wrapping DUT.
        vecs.push_back(mk("t3_load002",     0, 0, 1, 0, 12'h002, 12'h002, 0, 0, 0));
        vecs.push_back(mk("t3_start_down",  1, 0, 0, 1, 12'h000, 12'h002, 1, 0, 0));
        vecs.push_back(mk("t3_p1",          0, 0, 0, 1, 12'h000, 12'h002, 1, 0, 0));
        vecs.push_back(mk("t3_p2",          0, 0, 0, 1, 12'h000, 12'h002, 1, 0, 0));
        vecs.push_back(mk("t3_tick1",       0, 0, 0, 1, 12'h000, 12'h002, 1, 1, 0));
        vecs.push_back(mk("t3_at001",       0, 0, 0, 1, 12'h000, 12'h001, 1, 0, 0));
        vecs.push_back(mk("t3_p1b",         0, 0, 0, 1, 12'h000, 12'h001, 1, 0, 0));
        vecs.push_back(mk("t3_p2b",         0, 0, 0, 1, 12'h000, 12'h001, 1, 0, 0));
        vecs.push_back(mk("t3_terminal",    0, 0, 0, 1, 12'h000, 12'h001, 1, 1, 1));
        vecs.push_back(mk("t3_expired",     0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("t3_ss_ignored",  1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("t3_still_exp",   0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("t3_clear",       0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("t3_restart_up",  1, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0));
        vecs.push_back(mk("t5_p1",          0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0));
        vecs.push_back(mk("t5_p2",          0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0));
        vecs.push_back(mk("t5_tick",        0, 0, 0, 0, 12'h000, 12'h000, 1, 1, 0));
        vecs.push_back(mk("t5_ss_on_tick",  1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0));
        vecs.push_back(mk("t5_stopped",     0, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0));
        vecs.push_back(mk("t5_start",       1, 0, 0, 0, 12'h000, 12'h001, 1, 0, 0));
        vecs.push_back(mk("t5_load_run",    0, 0, 1, 0, 12'h777, 12'h001, 1, 0, 0));
        vecs.push_back(mk("t5_p2c",         0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 0));
        vecs.push_back(mk("t5_tickc",       0, 0, 0, 0, 12'h000, 12'h001, 1, 1, 0));
        vecs.push_back(mk("t5_at002",       0, 0, 0, 0, 12'h000, 12'h002, 1, 0, 0));
        vecs.push_back(mk("t5_stop",        1, 0, 0, 0, 12'h000, 12'h002, 0, 0, 0));
        vecs.push_back(mk("t5_clear",       0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("t5_down_at0",    1, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("t5_up_at0",      1, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0));
        vecs.push_back(mk("t5_stop2",       1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("t5_clamp3",      0, 0, 1, 0, 12'hF3B, 12'h939, 0, 0, 0));

        // T1: free-running up count, tick every 4th cycle.
        doReset("reset_init");
        pushExpect(0, "t1_start", 12'h000, 12'h000, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000);
        for (int k = 1; k <= 40; k++) begin
            c = bcd3(k / 4);
            pushExpect(0, "t1_run", c, c, 1, 0, (k % 4 == 3), 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 12'h000);
        end
        pushExpect(0, "t1_stop", 12'h010, 12'h010, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000);

        // T2: overflow from 998, wrapping vs saturating DUTs side by side.
        doReset("reset_t2");
        pushExpect(0, "t2_load", 12'h998, 12'h998, 0, 0, 0, 0);
        pushExpect(1, "t2_load", 12'h998, 12'h998, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 12'h998);
        pushExpect(0, "t2_start", 12'h998, 12'h998, 1, 0, 0, 0);
        pushExpect(1, "t2_start", 12'h998, 12'h998, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000);
        for (int k = 1; k <= 14; k++) begin
            logic ss_now, t_now, run_a;
            ss_now = (k == 13);
            t_now  = (k % 4 == 3);
            run_a  = (k < 13);
            c = bcd3((998 + k / 4) % 1000);
            if (k >= 13) c = bcd3(1);
            pushExpect(0, "t2_wrap", c, c, run_a, 0, t_now && run_a,
                       t_now && run_a && (998 + k / 4 == 999));
            if (k < 8)
                pushExpect(1, "t2_sat", bcd3(998 + k / 4), bcd3(998 + k / 4), 1, 0, t_now, k == 7);
            else
                pushExpect(1, "t2_sat_hold", 12'h999, 12'h999, 0, 0, 0, 0);
            applyStimulus(0, ss_now, 0, 0, 0, 0, 12'h000);
        end

        // T3 and single-cycle T5 corner cases from the table.
        doReset("reset_table");
        for (int i = 0; i < vecs.size(); i++) begin
            pushExpect(0, vecs[i].name, vecs[i].cnt, vecs[i].cnt, vecs[i].run, 0, vecs[i].tk, vecs[i].tm);
            applyStimulus(0, vecs[i].ss, vecs[i].clr, vecs[i].ld, 0, vecs[i].d, vecs[i].lv);
        end

        // T4: lap freeze while running from 045, unfreeze, refreeze, clear.
        doReset("reset_t4");
        pushExpect(0, "t4_load", 12'h045, 12'h045, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 12'h045);
        pushExpect(0, "t4_start", 12'h045, 12'h045, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000);
        for (int k = 1; k <= 22; k++) begin
            c   = bcd3(45 + k / 4);
            la  = (k <= 20) || (k == 22);
            dsp = !la ? c : ((k <= 20) ? 12'h045 : 12'h050);
            pushExpect(0, "t4_lap", c, dsp, 1, la, (k % 4 == 3), 0);
            applyStimulus(0, 0, 0, 0, (k == 1) || (k == 21) || (k == 22), 0, 12'h000);
        end
        pushExpect(0, "t4_clear_frozen", 12'h000, 12'h000, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 12'h000);
        for (int m = 1; m <= 4; m++) begin
            c = (m == 4) ? 12'h001 : 12'h000;
            pushExpect(0, "t4_after_clear", c, c, 1, 0, (m == 3), 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 12'h000);
        end
        pushExpect(0, "t4_stop", 12'h001, 12'h001, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000);

        // T5: load clamp on the 2-digit DUT, then reset in the middle of a run.
        doReset("reset_t5");
        pushExpect(2, "t5_clamp_a5", 12'h095, 12'h095, 0, 0, 0, 0);
        pushExpect(0, "t5_clamp_0a5", 12'h095, 12'h095, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 12'h0A5);
        pushExpect(0, "t5_mr_start", 12'h095, 12'h095, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000);
        pushExpect(0, "t5_mr_lap", 12'h095, 12'h095, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 12'h000);
        pushExpect(0, "t5_mr_p2", 12'h095, 12'h095, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 12'h000);
        pushExpect(0, "t5_mr_tick", 12'h095, 12'h095, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 12'h000);
        doReset("t5_midrun_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
